// File: rtl/ffre_pkg.sv
// ffre_pkg: shared state encoding and CRC-8 constants/step function for the register readback.
//   state_t   : IDLE, SEND (data beats), CRCB (CRC beat), DONE (completion pulse)
//   crc8_step : one byte of CRC-8 (poly 0x07), MSB first, no reflection
package ffre_pkg;
    typedef enum logic [1:0] {IDLE, SEND, CRCB, DONE} state_t;
    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) c = c[7] ? {c[6:0], 1'b0} ^ CRC8_POLY : {c[6:0], 1'b0};
        return c;
    endfunction
endpackage

// File: rtl/ffre_readback_if.sv
// ffre_readback_if: request/stream bundle between a readback engine and its capture path.
//   start/snap_data : snapshot request and register bank contents (index 0 sent first)
//   out_*           : valid/ready beat stream, out_last marks the CRC beat
//   busy/done       : transfer in flight / one-cycle completion pulse
//   master = readback engine, slave = capture side
interface ffre_readback_if #(
    parameter int WIDTH   = 101,
    parameter int SHIFT_W = 8
);
    logic               start;
    logic [0:WIDTH-1]   snap_data;
    logic               out_valid;
    logic               out_ready;
    logic [SHIFT_W-1:0] out_data;
    logic               out_last;
    logic               busy;
    logic               done;
    modport master (input start, snap_data, out_ready, output out_valid, out_data, out_last, busy, done);
    modport slave (output start, snap_data, out_ready, input out_valid, out_data, out_last, busy, done);
endinterface

// File: rtl/ffre_crc8.sv
// ffre_crc8: running CRC-8 over a byte stream, one byte per enabled cycle.
//   clk/clr : clock, asynchronous active-low reset
//   i_clear : reload CRC8_INIT (wins over i_en)
//   i_en    : fold i_data into the CRC
//   o_crc   : current CRC value
module ffre_crc8
    import ffre_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic       i_clear,
    input  logic       i_en,
    input  logic [7:0] i_data,
    output logic [7:0] o_crc
);
    logic [7:0] r_crc;
    always_ff @(posedge clk or negedge clr)
        if (!clr) r_crc <= '0;
        else if (i_clear) r_crc <= CRC8_INIT;
        else if (i_en) r_crc <= crc8_step(r_crc, i_data);
    assign o_crc = r_crc;
endmodule

// File: rtl/ffre_readback.sv
// ffre_readback: snapshots a register bank and streams it out in SHIFT_W-bit beats plus a CRC-8 beat.
//   clk/clr : clock, asynchronous active-low reset (abandons any transfer)
//   bus     : ffre_readback_if master (start/snap_data in, beat stream and busy/done out)
module ffre_readback
    import ffre_pkg::*;
#(
    parameter int WIDTH   = 101,
    parameter int SHIFT_W = 8
) (
    input logic            clk,
    input logic            clr,
    ffre_readback_if.master bus
);
    localparam int NBEATS = (WIDTH + SHIFT_W - 1) / SHIFT_W;
    localparam int NBITS  = NBEATS * SHIFT_W;
    localparam int KW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int PW     = (NBITS > 1) ? $clog2(NBITS) : 1;
    state_t             r_state, w_next;
    logic [0:WIDTH-1]   r_snap;
    logic [KW-1:0]      r_k;
    logic [0:NBITS-1]   w_pad;
    logic [PW-1:0]      w_base;
    logic [SHIFT_W-1:0] w_beat;
    logic [7:0]         w_crc;
    logic               w_accept, w_beat_hs, w_last_beat;
    assign w_accept    = (r_state == IDLE) && bus.start;
    assign w_beat_hs   = (r_state == SEND) && bus.out_ready;
    assign w_last_beat = (r_k == KW'(NBEATS - 1));
    // Pad to whole beats; the ascending range makes the lowest index land in the beat MSB.
    always_comb begin
        w_pad = '0;
        w_pad[0:WIDTH-1] = r_snap;
    end
    assign w_base = PW'(r_k * SHIFT_W);
    assign w_beat = w_pad[w_base +: SHIFT_W];
    ffre_crc8 u_crc (
        .clk     (clk),
        .clr     (clr),
        .i_clear (w_accept),
        .i_en    (w_beat_hs),
        .i_data  (8'(w_beat)),
        .o_crc   (w_crc)
    );
    always_ff @(posedge clk or negedge clr)
        if (!clr) r_state <= IDLE;
        else r_state <= w_next;
    // Counter parks on the last beat so the beat select never leaves the padded vector.
    always_ff @(posedge clk or negedge clr)
        if (!clr) begin
            r_snap <= '0;
            r_k    <= '0;
        end else if (w_accept) begin
            r_snap <= bus.snap_data;
            r_k    <= '0;
        end else if (w_beat_hs && !w_last_beat) r_k <= r_k + 1'b1;
    always_comb begin
        w_next        = r_state;
        bus.out_valid = 1'b0;
        bus.out_last  = 1'b0;
        bus.out_data  = '0;
        bus.done      = 1'b0;
        bus.busy      = (r_state != IDLE);
        case (r_state)
            IDLE: if (bus.start) w_next = SEND;
            SEND: begin
                bus.out_valid = 1'b1;
                bus.out_data  = w_beat;
                if (bus.out_ready && w_last_beat) w_next = CRCB;
            end
            CRCB: begin
                bus.out_valid = 1'b1;
                bus.out_last  = 1'b1;
                bus.out_data  = SHIFT_W'(w_crc);
                if (bus.out_ready) w_next = DONE;
            end
            DONE: begin
                bus.done = 1'b1;
                w_next   = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_ffre_readback.sv
// tb_ffre_readback: scoreboard bench for ffre_readback at WIDTH=101 and WIDTH=8.
module tb_ffre_readback;
    logic clk;
    logic clr;
    int   n_pass;
    int   n_total;
    logic [7:0] q[$];
    logic [7:0] qb[$];
    logic [7:0] rx[0:13];
    int   last_busy;

    ffre_readback_if #(.WIDTH(101), .SHIFT_W(8)) ia ();
    ffre_readback_if #(.WIDTH(8), .SHIFT_W(8)) ib ();

    ffre_readback #(.WIDTH(101), .SHIFT_W(8)) u_a (.clk(clk), .clr(clr), .bus(ia));
    ffre_readback #(.WIDTH(8), .SHIFT_W(8)) u_b (.clk(clk), .clr(clr), .bus(ib));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected stream: 13 packed beats, then a CRC computed bit-serially over the padded stream.
    task automatic push_a(input logic [0:100] s);
        logic [7:0] b;
        logic [7:0] crc;
        logic       bit_v;
        logic       fb;
        crc = 8'h00;
        for (int k = 0; k < 13; k++) begin
            for (int j = 0; j < 8; j++) begin
                bit_v = (k * 8 + j < 101) ? s[k * 8 + j] : 1'b0;
                b[7 - j] = bit_v;
                fb = crc[7] ^ bit_v;
                crc = {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
            end
            q.push_back(b);
        end
        q.push_back(crc);
    endtask

    // mode 0: always ready, 1: ready 1,0,0,1 pattern, 2: restart+snap change at beat 5, 3: clr at beat 4
    task automatic run_a(input logic [0:100] s, input int mode);
        int         hs;
        int         busy_n;
        int         last_hs;
        bit         done_seen;
        bit         stalled;
        bit         injected;
        bit         r;
        logic [7:0] held;
        logic [7:0] e;
        q.delete();
        push_a(s);
        hs = 0; busy_n = 0; last_hs = -10; done_seen = 0; stalled = 0; injected = 0; held = '0;
        @(negedge clk);
        ia.snap_data = s; ia.start = 1'b1; ia.out_ready = 1'b1;
        @(negedge clk);
        ia.start = 1'b0;
        n_total++;
        if (ia.out_valid !== 1'b1) $display("FAIL first_valid: got %b expected 1", ia.out_valid);
        else n_pass++;
        for (int cyc = 0; cyc < 200 && !done_seen; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (mode == 3 && hs == 4) begin
                clr = 1'b0;
                #1;
                n_total++;
                if ({ia.out_valid, ia.out_last, ia.busy, ia.done, ia.out_data} !== 12'h000)
                    $display("FAIL async_clear: got v%b l%b b%b d%b data %h expected all 0", ia.out_valid, ia.out_last, ia.busy, ia.done, ia.out_data);
                else n_pass++;
                q.delete();
                return;
            end
            if (ia.busy) busy_n++;
            if (ia.done) begin
                done_seen = 1;
                n_total++;
                if (cyc !== last_hs + 1) $display("FAIL done_timing: got cycle %0d expected %0d", cyc, last_hs + 1);
                else n_pass++;
            end
            if (stalled) begin
                n_total++;
                if (ia.out_valid !== 1'b1 || ia.out_data !== held)
                    $display("FAIL stall_hold: got v%b data %h expected v1 data %h", ia.out_valid, ia.out_data, held);
                else n_pass++;
            end
            r = (mode == 1) ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
            if (mode == 2 && hs == 5 && !injected) begin
                ia.start = 1'b1; ia.snap_data = ~s; injected = 1;
            end else ia.start = 1'b0;
            ia.out_ready = r;
            stalled = 0;
            if (ia.out_valid && r) begin
                n_total++;
                if (q.size() == 0) $display("FAIL extra_beat: got %h expected none", ia.out_data);
                else begin
                    e = q.pop_front();
                    if (ia.out_data !== e || ia.out_last !== (q.size() == 0))
                        $display("FAIL beat%0d: got data %h last %b expected data %h last %b", hs, ia.out_data, ia.out_last, e, q.size() == 0);
                    else n_pass++;
                end
                if (hs < 14) rx[hs] = ia.out_data;
                hs++;
                last_hs = cyc;
            end else if (ia.out_valid) begin
                stalled = 1;
                held = ia.out_data;
            end
        end
        ia.out_ready = 1'b1;
        last_busy = busy_n;
        n_total++;
        if (!done_seen || hs != 14 || q.size() != 0)
            $display("FAIL stream_end: got done %b beats %0d left %0d expected done 1 beats 14 left 0", done_seen, hs, q.size());
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (ia.done !== 1'b0 || ia.busy !== 1'b0)
            $display("FAIL idle_after: got done %b busy %b expected 0 0", ia.done, ia.busy);
        else n_pass++;
    endtask

    task automatic run_b(input logic [0:7] s, input logic [7:0] eb, input logic [7:0] ec);
        bit         seen;
        logic [7:0] e;
        qb.delete();
        qb.push_back(eb);
        qb.push_back(ec);
        seen = 0;
        @(negedge clk);
        ib.snap_data = s; ib.start = 1'b1; ib.out_ready = 1'b1;
        @(negedge clk);
        ib.start = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (c > 0) @(negedge clk);
            if (ib.done) seen = 1;
            else if (ib.out_valid) begin
                n_total++;
                if (qb.size() == 0) $display("FAIL w8_extra: got %h expected none", ib.out_data);
                else begin
                    e = qb.pop_front();
                    if (ib.out_data !== e || ib.out_last !== (qb.size() == 0))
                        $display("FAIL w8_beat snap %b: got data %h last %b expected data %h last %b", s, ib.out_data, ib.out_last, e, qb.size() == 0);
                    else n_pass++;
                end
            end
        end
        n_total++;
        if (!seen || qb.size() != 0) $display("FAIL w8_end: got done %b left %0d expected done 1 left 0", seen, qb.size());
        else n_pass++;
    endtask

    task automatic test_reset;
        #12;
        n_total++;
        if ({ia.out_valid, ia.out_last, ia.busy, ia.done, ia.out_data} !== 12'h000)
            $display("FAIL reset_a: got v%b l%b b%b d%b data %h expected all 0", ia.out_valid, ia.out_last, ia.busy, ia.done, ia.out_data);
        else n_pass++;
        n_total++;
        if ({ib.out_valid, ib.out_last, ib.busy, ib.done, ib.out_data} !== 12'h000)
            $display("FAIL reset_b: got v%b l%b b%b d%b data %h expected all 0", ib.out_valid, ib.out_last, ib.busy, ib.done, ib.out_data);
        else n_pass++;
        @(negedge clk);
        clr = 1'b1;
    endtask

    task automatic test_zero;
        run_a('0, 0);
        n_total++;
        if (last_busy != 15) $display("FAIL busy_len: got %0d expected 15", last_busy);
        else n_pass++;
        n_total++;
        if (rx[13] !== 8'h00) $display("FAIL zero_crc: got %h expected 00", rx[13]);
        else n_pass++;
    endtask

    task automatic test_width8;
        run_b(8'b0000_0001, 8'h01, 8'h07);
        run_b(8'b1000_0000, 8'h80, 8'h89);
        run_b(8'b1111_1111, 8'hFF, 8'hF3);
    endtask

    task automatic test_top_bit;
        logic [0:100] s;
        s = '0;
        s[100] = 1'b1;
        run_a(s, 0);
        n_total++;
        if (rx[12] !== 8'h08) $display("FAIL top_bit_beat12: got %h expected 08", rx[12]);
        else n_pass++;
    endtask

    task automatic test_backpressure;
        logic [0:100] s;
        logic [7:0]   crc_ref;
        s = 101'({$urandom(), $urandom(), $urandom(), $urandom()});
        run_a(s, 0);
        crc_ref = rx[13];
        run_a(s, 1);
        n_total++;
        if (rx[13] !== crc_ref) $display("FAIL stalled_crc: got %h expected %h", rx[13], crc_ref);
        else n_pass++;
    endtask

    task automatic test_restart_ignored;
        logic [0:100] s;
        s = 101'({$urandom(), $urandom(), $urandom(), $urandom()});
        run_a(s, 2);
    endtask

    task automatic test_clear;
        logic [0:100] s;
        bit           saw_done;
        s = 101'({$urandom(), $urandom(), $urandom(), $urandom()});
        run_a(s, 3);
        saw_done = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (ia.done) saw_done = 1;
        end
        n_total++;
        if (saw_done) $display("FAIL clear_no_done: got done pulse expected none");
        else n_pass++;
        clr = 1'b1;
        @(negedge clk);
        run_a(~s, 0);
    endtask

    initial begin
        n_pass = 0; n_total = 0; clr = 1'b0; last_busy = 0;
        ia.start = 1'b0; ia.snap_data = '0; ia.out_ready = 1'b0;
        ib.start = 1'b0; ib.snap_data = '0; ib.out_ready = 1'b0;
        test_reset;
        test_zero;
        test_width8;
        test_top_bit;
        test_backpressure;
        test_restart_ignored;
        test_clear;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
